// File: rtl/alu_seq_ctrl.sv
// alu_seq_ctrl: multi-cycle sequencer driving regfile/shifter/ALU strobes per accepted command
module alu_seq_ctrl #(
  parameter int DATA_W = 16,
  parameter int IMM_W  = 8,
  parameter int RN_W   = 3
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [2:0]        cmd_op,
  input  logic [RN_W-1:0]   cmd_rd,
  input  logic [RN_W-1:0]   cmd_rn,
  input  logic [RN_W-1:0]   cmd_rm,
  input  logic [1:0]        cmd_shift,
  input  logic [IMM_W-1:0]  cmd_imm,
  output logic [RN_W-1:0]   readnum,
  output logic [RN_W-1:0]   writenum,
  output logic              write,
  output logic              loada,
  output logic              loadb,
  output logic              loadc,
  output logic              loads,
  output logic              asel,
  output logic              vsel,
  output logic [1:0]        shift,
  output logic [1:0]        alu_op,
  output logic [DATA_W-1:0] sximm,
  output logic              done,
  output logic              err
);
  localparam logic [2:0] IDLE = 3'd0, LD_A = 3'd1, LD_B = 3'd2, EXEC = 3'd3,
                         WB_C = 3'd4, WB_IMM = 3'd5, DONE = 3'd6;
  localparam logic [2:0] MOV_IMM = 3'd0, MOV_REG = 3'd1, ADD = 3'd2, CMP = 3'd3,
                         AND_OP = 3'd4, MVN = 3'd5;
  logic [2:0]       state, nxt, first, op;
  logic [RN_W-1:0]  rd, rn, rm, rnum_q, wnum_q;
  logic [1:0]       sh;
  logic [IMM_W-1:0] imm;
  logic             ex;
  always_comb begin
    first = (cmd_op == ADD || cmd_op == CMP || cmd_op == AND_OP) ? LD_A :
            (cmd_op == MOV_REG || cmd_op == MVN) ? LD_B :
            cmd_op == MOV_IMM ? WB_IMM : DONE;
    nxt = state == IDLE ? (cmd_valid ? first : IDLE) :
          state == LD_A ? LD_B :
          state == LD_B ? EXEC :
          state == EXEC ? (op == CMP ? DONE : WB_C) :
          state == DONE ? IDLE : DONE;
  end
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      state  <= IDLE;
      op     <= '0;
      rd     <= '0;
      rn     <= '0;
      rm     <= '0;
      sh     <= '0;
      imm    <= '0;
      rnum_q <= '0;
      wnum_q <= '0;
    end else begin
      state  <= nxt;
      rnum_q <= readnum;
      wnum_q <= writenum;
      if (cmd_valid && cmd_ready) begin
        op  <= cmd_op;
        rd  <= cmd_rd;
        rn  <= cmd_rn;
        rm  <= cmd_rm;
        sh  <= cmd_shift;
        imm <= cmd_imm;
      end
    end
  // register indices persist outside the states that drive them
  always_comb begin
    ex        = state == EXEC;
    cmd_ready = state == IDLE;
    readnum   = state == LD_A ? rn : state == LD_B ? rm : rnum_q;
    writenum  = (state == WB_C || state == WB_IMM) ? rd : wnum_q;
    write     = state == WB_C || state == WB_IMM;
    vsel      = state == WB_IMM;
    loada     = state == LD_A;
    loadb     = state == LD_B;
    loadc     = ex && op != CMP;
    loads     = ex;
    asel      = ex && (op == MOV_REG || op == MVN);
    shift     = ex ? sh : 2'b00;
    alu_op    = !ex ? 2'b00 : op == CMP ? 2'b01 : op == AND_OP ? 2'b10 : op == MVN ? 2'b11 : 2'b00;
    done      = state == DONE;
    err       = state == DONE && op[2:1] == 2'b11;
    sximm     = {{(DATA_W-IMM_W){imm[IMM_W-1]}}, imm};
  end
endmodule

// File: tb/tb_alu_seq_ctrl.sv
// tb_alu_seq_ctrl: scoreboard bench; per-cycle expected strobe vectors queued at issue, popped each cycle
module tb_alu_seq_ctrl;
  logic        clk = 0, reset_n = 0, cmd_valid = 0, cmd_ready;
  logic [2:0]  cmd_op = 0, cmd_rd = 0, cmd_rn = 0, cmd_rm = 0, readnum, writenum;
  logic [1:0]  cmd_shift = 0, shift, alu_op;
  logic [7:0]  cmd_imm = 0;
  logic [15:0] sximm;
  logic        write, loada, loadb, loadc, loads, asel, vsel, done, err;
  logic [19:0] dv, e;
  logic [19:0] q[$];
  logic [2:0]  c_op, c_rd, c_rn, c_rm, rnum = 0, wnum = 0;
  logic [1:0]  c_sh;
  int n_cmp = 0, n_bad = 0;

  alu_seq_ctrl dut (
    .clk(clk), .reset_n(reset_n), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_op(cmd_op), .cmd_rd(cmd_rd), .cmd_rn(cmd_rn), .cmd_rm(cmd_rm),
    .cmd_shift(cmd_shift), .cmd_imm(cmd_imm), .readnum(readnum), .writenum(writenum),
    .write(write), .loada(loada), .loadb(loadb), .loadc(loadc), .loads(loads),
    .asel(asel), .vsel(vsel), .shift(shift), .alu_op(alu_op), .sximm(sximm),
    .done(done), .err(err)
  );

  always #5 clk = ~clk;
  assign dv = {readnum, writenum, write, loada, loadb, loadc, loads, asel, vsel,
               shift, alu_op, done, err, cmd_ready};

  task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // st: 1 LD_A, 2 LD_B, 3 EXEC, 4 WB_C, 5 WB_IMM, 6 DONE
  task automatic push_st(int st);
    logic wr = 0, la = 0, lb = 0, lc = 0, ls = 0, as = 0, vs = 0, dn = 0, er = 0;
    logic [1:0] sh = 0, ao = 0;
    case (st)
      1: begin rnum = c_rn; la = 1; end
      2: begin rnum = c_rm; lb = 1; end
      3: begin
        sh = c_sh;
        as = c_op == 1 || c_op == 5;
        ao = c_op == 3 ? 2'd1 : c_op == 4 ? 2'd2 : c_op == 5 ? 2'd3 : 2'd0;
        lc = c_op != 3;
        ls = 1;
      end
      4: begin wnum = c_rd; wr = 1; end
      5: begin wnum = c_rd; wr = 1; vs = 1; end
      default: begin dn = 1; er = c_op >= 6; end
    endcase
    q.push_back({rnum, wnum, wr, la, lb, lc, ls, as, vs, sh, ao, dn, er, 1'b0});
  endtask

  task automatic push_path();
    case (c_op)
      2, 4: begin push_st(1); push_st(2); push_st(3); push_st(4); push_st(6); end
      3:    begin push_st(1); push_st(2); push_st(3); push_st(6); end
      1, 5: begin push_st(2); push_st(3); push_st(4); push_st(6); end
      0:    begin push_st(5); push_st(6); end
      default: push_st(6);
    endcase
  endtask

  task automatic drive(logic [2:0] op, rd, rn, rm, logic [1:0] sh, logic [7:0] imm);
    cmd_op = op; cmd_rd = rd; cmd_rn = rn; cmd_rm = rm; cmd_shift = sh; cmd_imm = imm;
    cmd_valid = 1;
    c_op = op; c_rd = rd; c_rn = rn; c_rm = rm; c_sh = sh;
  endtask

  task automatic drain(string tag);
    while (q.size() > 0) begin
      @(negedge clk);
      e = q.pop_front();
      chk(tag, dv, e);
    end
  endtask

  task automatic run_cmd(logic [2:0] op, rd, rn, rm, logic [1:0] sh, logic [7:0] imm);
    @(negedge clk);
    drive(op, rd, rn, rm, sh, imm);
    chk("ready", cmd_ready, 1);
    push_path();
    @(posedge clk);
    #1 cmd_valid = 0;
    drain($sformatf("op%0d", op));
    chk("sximm", sximm, {{8{imm[7]}}, imm});
  endtask

  initial begin
    repeat (2) @(negedge clk);
    chk("rst_out", dv, 20'h1);
    chk("rst_sximm", sximm, 0);
    reset_n = 1;
    @(negedge clk);
    chk("ready_after_rst", cmd_ready, 1);
    run_cmd(3'd2, 3'd2, 3'd0, 3'd1, 2'b00, 8'h00);
    run_cmd(3'd3, 3'd0, 3'd3, 3'd4, 2'b00, 8'h00);
    run_cmd(3'd0, 3'd5, 3'd0, 3'd0, 2'b00, 8'hF6);
    run_cmd(3'd5, 3'd1, 3'd0, 3'd7, 2'b01, 8'h00);
    run_cmd(3'd7, 3'd4, 3'd2, 3'd3, 2'b10, 8'h00);
    run_cmd(3'd4, 3'd6, 3'd5, 3'd2, 2'b10, 8'h7F);
    run_cmd(3'd1, 3'd3, 3'd6, 3'd5, 2'b11, 8'h80);
    run_cmd(3'd6, 3'd7, 3'd1, 3'd1, 2'b00, 8'h01);
    run_cmd(3'd0, 3'd7, 3'd0, 3'd0, 2'b00, 8'h7F);
    // ADD held valid; async reset asserted mid-cycle in EXEC
    @(negedge clk);
    drive(3'd2, 3'd6, 3'd4, 3'd5, 2'b00, 8'h00);
    push_st(1); push_st(2); push_st(3);
    @(posedge clk);
    drain("held_add");
    #2 reset_n = 0;
    rnum = 0; wnum = 0;
    #1 chk("async_rst", dv, 20'h1);
    chk("async_rst_sximm", sximm, 0);
    @(negedge clk);
    chk("in_rst", dv, 20'h1);
    reset_n = 1;
    chk("reaccept_ready", cmd_ready, 1);
    push_path();
    @(posedge clk);
    #1 cmd_valid = 0;
    drain("reaccept");
    @(negedge clk);
    chk("final_idle", dv, {rnum, wnum, 13'b0, 1'b1});
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
